mvt_wrapper: RTL and testbench
==============================

MVT_WRAPPER -- requirements
Module: mvt_wrapper

Interface
REQ-001 Parameter N, default 4: matrix/vector dimension.
REQ-002 Parameter DATA_W, default 16: arithmetic word width in bits, unsigned.
REQ-003 ap_clk  input  1  single clock; all logic on the rising edge.
REQ-004 ap_rst  input  1  reset, asynchronous and active-high.
REQ-005 ap_start  input  1  level-sensitive run request.
REQ-006 data_out  output  4  result symbol, meaningful only while data_valid=1.
REQ-007 data_valid  output  1  one-cycle qualifier per emitted symbol.

Function
REQ-008 The block SHALL compute MVT self-contained:
- x1[i] += sum_j A[i][j]*y1[j];
- x2[i] += sum_j A[j][i]*y2[j].
REQ-009 Initial contents SHALL be built internally on every run: A[i][j]=i+j, y1[j]=j+1, y2[j]=1, x1[i]=i, x2[i]=0.
REQ-010 Arithmetic SHALL be modulo 2^DATA_W; products and sums wrap silently.
REQ-011 FSM states SHALL be IDLE, INIT, COMP1, COMP2, OUT, DONE.
REQ-012 IDLE->INIT SHALL occur on the first edge that samples ap_start=1.
REQ-013 INIT SHALL take N cycles, writing one index of x1/x2/y1/y2 per cycle; A is computed combinationally from indices.
REQ-014 COMP1 SHALL perform one MAC per cycle, j inner and i outer, N*N cycles, then enter COMP2.
REQ-015 COMP2 SHALL perform one MAC per cycle, N*N cycles, then enter OUT.
REQ-016 OUT SHALL emit x1[0..N-1] then x2[0..N-1], one word per cycle, data_valid=1 each cycle.
REQ-017 Default symbol SHALL be the XOR of all 4-bit nibbles of the word (DATA_W/4 nibbles).
REQ-018 After the last symbol the FSM SHALL enter DONE with data_valid=0 and data_out held at its last value.
REQ-019 DONE SHALL return to IDLE only after sampling ap_start=0; a held-high ap_start SHALL NOT cause a rerun.
REQ-020 ap_start changes outside IDLE/DONE SHALL be ignored.
REQ-021 Start-sample edge to first data_valid SHALL be exactly N + 2*N*N + 1 cycles: 37 for N=4.

Reset
REQ-022 While ap_rst=1: state=IDLE, data_out=0, data_valid=0, all counters 0.
REQ-023 Reset asserted mid-operation SHALL abort immediately with no further valid symbols.
REQ-024 After release, a new run SHALL start only on a sampled ap_start=1.

Configuration
REQ-025 Macro MVT_WRAPPER_NIBBLE_SERIAL_EN:
- Defined: each word SHALL be emitted as DATA_W/4 consecutive nibbles, LSB nibble first, data_valid=1 on every beat.
- Undefined: XOR-fold per REQ-017.
- Latency to the first symbol is unchanged.

Structure
REQ-026 Package mvt_wrapper_pkg SHALL hold N/DATA_W defaults, the FSM state enum, and the nibble-fold function.
REQ-027 Sub-module mvt_core SHALL hold the arrays, MAC datapath and index counters.
REQ-028 mvt_wrapper SHALL hold the FSM and output serializer.

Verification
REQ-029 Reset 100 ns, then ap_start=1 held, 10 ns clock -> 8 symbols 5,E,8,6,6,A,E,3 in consecutive cycles (x1=20,31,42,53; x2=6,10,14,18).
REQ-030 ap_start held high after DONE for 100 cycles -> no further data_valid pulses.
REQ-031 Drop ap_start for 1 cycle, then reassert -> identical 8-symbol sequence repeats.
REQ-032 Assert ap_rst at cycle 20 of a run -> data_valid=0 and data_out=0 immediately; a rerun then produces the correct full sequence.
REQ-033 With MVT_WRAPPER_NIBBLE_SERIAL_EN defined -> first word 20 (0x0014) emits 4,1,0,0, for 32 beats total.
REQ-034 Check first data_valid exactly 37 cycles after the start-sample edge (N=4).

Source files
------------

// File: rtl/mvt_wrapper_pkg.sv
// Shared definitions for the MVT wrapper: default sizes, FSM state encoding
// and the nibble XOR-fold used to compress a result word into one symbol.
`timescale 1ns/1ps
package mvt_wrapper_pkg;

    localparam int DEFAULT_N      = 4;
    localparam int DEFAULT_DATA_W = 16;
    localparam int MAX_DATA_W     = 64;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COMP1,
        COMP2,
        OUT,
        DONE
    } state_e;

    // Callers zero-extend their word to MAX_DATA_W and say how many nibbles are live.
    function automatic logic [3:0] nibbleFold(input logic [MAX_DATA_W-1:0] word,
                                              input int nibbles);
        logic [3:0] acc;
        acc = '0;
        for (int k = 0; k < MAX_DATA_W / 4; k++) begin
            if (k < nibbles) begin
                acc = acc ^ word[4*k +: 4];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/mvt_core.sv
// MVT datapath: x1/x2/y1/y2 storage, the shared MAC and the i/j index counters.
// Sequencing comes from the wrapper's FSM state.
`timescale 1ns/1ps
module mvt_core import mvt_wrapper_pkg::*; #(
    parameter  int N      = DEFAULT_N,
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  state_e            state_i,
    input  logic              rdSel_i,
    input  logic [IDX_W-1:0]  rdIdx_i,
    output logic [DATA_W-1:0] rdData_o,
    output logic              phaseLast_o
);

    logic [DATA_W-1:0] x1_q [N];
    logic [DATA_W-1:0] x2_q [N];
    logic [DATA_W-1:0] y1_q [N];
    logic [DATA_W-1:0] y2_q [N];
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  j_q;

    logic              iLast;
    logic              jLast;
    logic [DATA_W-1:0] aElem;
    logic [DATA_W-1:0] yElem;
    logic [DATA_W-1:0] accOld;
    logic [DATA_W-1:0] macSum;

    // A[i][j] = i+j is symmetric, so A[j][i] in the x2 pass yields the same element.
    always_comb begin
        iLast  = (i_q == IDX_W'(N - 1));
        jLast  = (j_q == IDX_W'(N - 1));
        aElem  = DATA_W'(i_q) + DATA_W'(j_q);
        yElem  = (state_i == COMP2) ? y2_q[j_q] : y1_q[j_q];
        accOld = (state_i == COMP2) ? x2_q[i_q] : x1_q[i_q];
        macSum = accOld + aElem * yElem;

        case (state_i)
            INIT:         phaseLast_o = iLast;
            COMP1, COMP2: phaseLast_o = iLast && jLast;
            default:      phaseLast_o = 1'b0;
        endcase

        rdData_o = rdSel_i ? x2_q[rdIdx_i] : x1_q[rdIdx_i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                x1_q[k] <= '0;
                x2_q[k] <= '0;
                y1_q[k] <= '0;
                y2_q[k] <= '0;
            end
            i_q <= '0;
            j_q <= '0;
        end else begin
            case (state_i)
                INIT: begin
                    x1_q[i_q] <= DATA_W'(i_q);
                    x2_q[i_q] <= '0;
                    y1_q[i_q] <= DATA_W'(i_q) + DATA_W'(1);
                    y2_q[i_q] <= DATA_W'(1);
                    i_q       <= iLast ? '0 : i_q + 1'b1;
                    j_q       <= '0;
                end
                COMP1, COMP2: begin
                    if (state_i == COMP1) begin
                        x1_q[i_q] <= macSum;
                    end else begin
                        x2_q[i_q] <= macSum;
                    end
                    j_q <= jLast ? '0 : j_q + 1'b1;
                    if (jLast) begin
                        i_q <= iLast ? '0 : i_q + 1'b1;
                    end
                end
                default: begin
                    i_q <= '0;
                    j_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mvt_wrapper.sv
// MVT top: run-control FSM and registered output serializer around mvt_core.
// Define MVT_WRAPPER_NIBBLE_SERIAL_EN to stream every nibble instead of the XOR-fold.
`timescale 1ns/1ps
module mvt_wrapper import mvt_wrapper_pkg::*; #(
    parameter int N      = DEFAULT_N,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic       ap_start,
    output logic [3:0] data_out,
    output logic       data_valid
);

    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int WORD_W  = $clog2(2 * N);
    localparam int NIBBLES = DATA_W / 4;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] wordIdx_q, wordIdx_d;
    logic [3:0]        dataOut_q, dataOut_d;
    logic              dataValid_q, dataValid_d;

    logic              phaseLast;
    logic              rdSel;
    logic [IDX_W-1:0]  rdIdx;
    logic [DATA_W-1:0] rdData;
    logic              wordLast;
    logic              beatLast;
    logic [3:0]        symbol;

`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    logic [NIB_W-1:0] nib_q, nib_d;
`endif

    mvt_core #(.N(N), .DATA_W(DATA_W)) u_core (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .state_i     (state_q),
        .rdSel_i     (rdSel),
        .rdIdx_i     (rdIdx),
        .rdData_o    (rdData),
        .phaseLast_o (phaseLast)
    );

    // Words 0..N-1 come from x1, words N..2N-1 from x2.
    always_comb begin
        wordLast = (wordIdx_q == WORD_W'(2 * N - 1));
        rdSel    = (wordIdx_q >= WORD_W'(N));
        rdIdx    = rdSel ? IDX_W'(wordIdx_q - WORD_W'(N)) : IDX_W'(wordIdx_q);
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
        symbol   = rdData[4*nib_q +: 4];
        beatLast = wordLast && (nib_q == NIB_W'(NIBBLES - 1));
`else
        symbol   = nibbleFold(MAX_DATA_W'(rdData), NIBBLES);
        beatLast = wordLast;
`endif
    end

    always_comb begin
        state_d     = state_q;
        wordIdx_d   = '0;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
        nib_d       = '0;
`endif
        case (state_q)
            IDLE:  if (ap_start)  state_d = INIT;
            INIT:  if (phaseLast) state_d = COMP1;
            COMP1: if (phaseLast) state_d = COMP2;
            COMP2: if (phaseLast) state_d = OUT;
            OUT: begin
                dataOut_d   = symbol;
                dataValid_d = 1'b1;
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
                if (nib_q == NIB_W'(NIBBLES - 1)) begin
                    wordIdx_d = wordIdx_q + 1'b1;
                end else begin
                    wordIdx_d = wordIdx_q;
                    nib_d     = nib_q + 1'b1;
                end
`else
                wordIdx_d = wordIdx_q + 1'b1;
`endif
                if (beatLast) begin
                    state_d   = DONE;
                    wordIdx_d = '0;
                end
            end
            DONE:    if (!ap_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            wordIdx_q   <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
            nib_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wordIdx_q   <= wordIdx_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
            nib_q       <= nib_d;
`endif
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;

endmodule

// File: tb/tb_mvt_wrapper.sv
// Directed self-checking bench for mvt_wrapper (N=4, DATA_W=16): latency,
// symbol stream, held-start lockout, restart and asynchronous reset abort.
`timescale 1ns/1ps
module tb_mvt_wrapper;

    localparam int N       = 4;
    localparam int DATA_W  = 16;
    localparam int LATENCY = 37;
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
    localparam int NSYM    = 32;
`else
    localparam int NSYM    = 8;
`endif

    logic       ap_clk;
    logic       ap_rst;
    logic       ap_start;
    logic [3:0] data_out;
    logic       data_valid;

    int nAsserts = 0;
    int nFails   = 0;

    logic [15:0] expWords [8];
    logic [3:0]  expSym   [NSYM];

    mvt_wrapper #(.N(N), .DATA_W(DATA_W)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Raises ap_start from IDLE and checks latency, the full stream and the idle tail.
    task automatic applyStimulus(input string tag);
        int cycles;
        ap_start = 1'b1;
        tick();
        cycles = 0;
        while (data_valid !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        checkOutput($sformatf("%s_latency", tag), cycles, LATENCY);
        for (int k = 0; k < NSYM; k++) begin
            if (k > 0) tick();
            checkOutput($sformatf("%s_valid%0d", tag, k), {31'd0, data_valid}, 1);
            checkOutput($sformatf("%s_sym%0d", tag, k), {28'd0, data_out}, {28'd0, expSym[k]});
        end
        tick();
        checkOutput($sformatf("%s_validLow", tag), {31'd0, data_valid}, 0);
        checkOutput($sformatf("%s_outHeld", tag), {28'd0, data_out}, {28'd0, expSym[NSYM-1]});
    endtask

    initial begin
        expWords = '{16'd20, 16'd31, 16'd42, 16'd53, 16'd6, 16'd10, 16'd14, 16'd18};
`ifdef MVT_WRAPPER_NIBBLE_SERIAL_EN
        for (int w = 0; w < 8; w++) begin
            for (int n = 0; n < 4; n++) begin
                expSym[w*4 + n] = expWords[w][4*n +: 4];
            end
        end
`else
        expSym = '{4'h5, 4'hE, 4'h8, 4'h6, 4'h6, 4'hA, 4'hE, 4'h3};
`endif

        $display("[TB] reset phase");
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        #100;
        checkOutput("reset_valid", {31'd0, data_valid}, 0);
        checkOutput("reset_out", {28'd0, data_out}, 0);
        tick();
        ap_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("idle_valid", {31'd0, data_valid}, 0);
        end

        $display("[TB] first run");
        applyStimulus("run1");

        $display("[TB] start held high after completion");
        for (int c = 0; c < 100; c++) begin
            tick();
            checkOutput("heldStart_valid", {31'd0, data_valid}, 0);
        end

        $display("[TB] restart after one-cycle drop");
        ap_start = 1'b0;
        tick();
        applyStimulus("run2");

        $display("[TB] reset 20 cycles into a run");
        ap_start = 1'b0;
        tick();
        ap_start = 1'b1;
        tick();
        repeat (20) tick();
        ap_rst = 1'b1;
        #1;
        checkOutput("rst20_valid", {31'd0, data_valid}, 0);
        checkOutput("rst20_out", {28'd0, data_out}, 0);
        tick();
        ap_start = 1'b0;
        ap_rst   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("rst20_idle_valid", {31'd0, data_valid}, 0);
        end
        applyStimulus("run3");

        $display("[TB] reset while symbols stream out");
        ap_start = 1'b0;
        tick();
        ap_start = 1'b1;
        tick();
        repeat (LATENCY + 1) tick();
        checkOutput("midOut_valid", {31'd0, data_valid}, 1);
        checkOutput("midOut_sym1", {28'd0, data_out}, {28'd0, expSym[1]});
        ap_rst = 1'b1;
        #1;
        checkOutput("midOutRst_valid", {31'd0, data_valid}, 0);
        checkOutput("midOutRst_out", {28'd0, data_out}, 0);
        ap_start = 1'b0;
        tick();
        ap_rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            checkOutput("midOutRst_noResume", {31'd0, data_valid}, 0);
        end
        applyStimulus("run4");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
